// File: rtl/counter_param.sv
// counter_param: registered up/down/step/load counter with terminal-count
// flag, per-cycle saturate/wrap selection, sticky overflow flag and a
// saturating count of modulo wraps. Every output comes straight from a flop.
module counter_param #(
  parameter int WIDTH  = 4,  // counter width, >= 2
  parameter int STEP   = 3,  // increment used in mode 2'b10, 1 <= STEP < 2**WIDTH
  parameter int WRAP_W = 4   // width of the wrap-event counter, >= 1
) (
  input  logic              clk,
  input  logic              reset,     // synchronous, active-low
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              sat,
  input  logic [WIDTH-1:0]  D,
  output logic [WIDTH-1:0]  Q,
  output logic              rco,
  output logic              load,
  output logic              ovf,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [WIDTH-1:0]  Q_MAX    = '1;
  localparam logic [WIDTH-1:0]  Q_ZERO   = '0;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
  localparam logic [WIDTH:0]    INC_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]    INC_STEP = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0]  q_reg, q_next;
  logic              rco_reg, rco_next;
  logic              load_reg, load_next;
  logic              ovf_reg, ovf_next;
  logic [WRAP_W-1:0] wrap_reg, wrap_next;

  logic [WIDTH:0]    inc;
  logic [WIDTH:0]    sum;
  logic              wrap_event;

  // Upward sum one bit wider than Q so the carry out is visible.
  always_comb begin
    inc = (mode == MODE_STEP) ? INC_STEP : INC_ONE;
    sum = {1'b0, q_reg} + inc;
  end

  // Next-state for value and flags; rco/load are pulses that default low.
  always_comb begin
    q_next     = q_reg;
    rco_next   = 1'b0;
    load_next  = 1'b0;
    ovf_next   = ovf_reg;
    wrap_event = 1'b0;

    if (enable) begin
      case (mode)
        MODE_UP, MODE_STEP: begin
          if (sum[WIDTH]) begin
            ovf_next = 1'b1;
            if (sat) begin
              q_next = Q_MAX;
            end else begin
              q_next     = sum[WIDTH-1:0];
              wrap_event = 1'b1;
            end
          end else begin
            q_next = sum[WIDTH-1:0];
          end
          rco_next = (q_next == Q_MAX);
        end
        MODE_DOWN: begin
          if (q_reg == Q_ZERO) begin
            ovf_next = 1'b1;
            if (sat) begin
              q_next = Q_ZERO;
            end else begin
              q_next     = Q_MAX;
              wrap_event = 1'b1;
            end
          end else begin
            q_next = q_reg - 1'b1;
          end
          rco_next = (q_next == Q_ZERO);
        end
        MODE_LOAD: begin
          q_next    = D;
          load_next = 1'b1;
          ovf_next  = 1'b0;
        end
        default: begin
          q_next = q_reg;
        end
      endcase
    end
  end

  // Wrap-event counter sticks at its maximum instead of rolling over.
  always_comb begin
    wrap_next = wrap_reg;
    if (wrap_event && (wrap_reg != WRAP_MAX)) begin
      wrap_next = wrap_reg + 1'b1;
    end
  end

  // State register; reset wins over load, wrap and hold alike.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg    <= '0;
      rco_reg  <= 1'b0;
      load_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      wrap_reg <= '0;
    end else begin
      q_reg    <= q_next;
      rco_reg  <= rco_next;
      load_reg <= load_next;
      ovf_reg  <= ovf_next;
      wrap_reg <= wrap_next;
    end
  end

  assign Q        = q_reg;
  assign rco      = rco_reg;
  assign load     = load_reg;
  assign ovf      = ovf_reg;
  assign wrap_cnt = wrap_reg;

endmodule

// File: tb/tb_counter_param.sv
// tb_counter_param: scoreboard bench for counter_param. Two instances share
// the stimulus: the default configuration and one with a 2-bit wrap counter.
module tb_counter_param;

  localparam int W     = 4;
  localparam int STEPV = 3;
  localparam int QMAX  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [1:0]   mode;
  logic         sat;
  logic [W-1:0] D;

  logic [W-1:0] q_a;
  logic         rco_a, load_a, ovf_a;
  logic [3:0]   wrap_a;
  logic [W-1:0] q_b;
  logic         rco_b, load_b, ovf_b;
  logic [1:0]   wrap_b;

  counter_param #(.WIDTH(W), .STEP(STEPV), .WRAP_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sat(sat), .D(D),
    .Q(q_a), .rco(rco_a), .load(load_a), .ovf(ovf_a), .wrap_cnt(wrap_a)
  );

  counter_param #(.WIDTH(W), .STEP(STEPV), .WRAP_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sat(sat), .D(D),
    .Q(q_b), .rco(rco_b), .load(load_b), .ovf(ovf_b), .wrap_cnt(wrap_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int rco;
    int load;
    int ovf;
    int w4;
    int w2;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // reference state
  int m_q = 0, m_rco = 0, m_load = 0, m_ovf = 0, m_w4 = 0, m_w2 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s txn %0d: got %0d expected %0d", tag, txn, got, want);
    end
  endtask

  // Behavioural reference: integer arithmetic against the numeric range.
  task automatic model(input bit rst_i, input bit en_i, input int mode_i,
                       input bit sat_i, input int d_i);
    int s;
    bit wrapped;
    wrapped = 1'b0;
    if (!rst_i) begin
      m_q = 0; m_rco = 0; m_load = 0; m_ovf = 0; m_w4 = 0; m_w2 = 0;
    end else if (!en_i) begin
      m_rco = 0; m_load = 0;
    end else begin
      m_load = 0;
      if (mode_i == 0 || mode_i == 2) begin
        s = m_q + ((mode_i == 0) ? 1 : STEPV);
        if (s > QMAX) begin
          m_ovf = 1;
          if (sat_i) m_q = QMAX;
          else begin m_q = s - (QMAX + 1); wrapped = 1'b1; end
        end else m_q = s;
        m_rco = (m_q == QMAX) ? 1 : 0;
      end else if (mode_i == 1) begin
        if (m_q == 0) begin
          m_ovf = 1;
          if (!sat_i) begin m_q = QMAX; wrapped = 1'b1; end
        end else m_q = m_q - 1;
        m_rco = (m_q == 0) ? 1 : 0;
      end else begin
        m_q = d_i; m_load = 1; m_rco = 0; m_ovf = 0;
      end
      if (wrapped) begin
        if (m_w4 < 15) m_w4++;
        if (m_w2 < 3)  m_w2++;
      end
    end
  endtask

  // Drive one cycle, push the expectation, then pop and compare after the edge.
  task automatic step(input bit rst_i, input bit en_i, input int mode_i,
                      input bit sat_i, input int d_i);
    exp_t e;
    reset  = rst_i;
    enable = en_i;
    mode   = 2'(mode_i);
    sat    = sat_i;
    D      = W'(d_i);
    model(rst_i, en_i, mode_i, sat_i, d_i);
    e.q = m_q; e.rco = m_rco; e.load = m_load; e.ovf = m_ovf; e.w4 = m_w4; e.w2 = m_w2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    txn++;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("Q",        32'(q_a),    32'(e.q));
      check("rco",      32'(rco_a),  32'(e.rco));
      check("load",     32'(load_a), 32'(e.load));
      check("ovf",      32'(ovf_a),  32'(e.ovf));
      check("wrap_cnt", 32'(wrap_a), 32'(e.w4));
      check("Q_w2",     32'(q_b),    32'(e.q));
      check("wrap_w2",  32'(wrap_b), 32'(e.w2));
    end
    $display("txn %0d rst=%0b en=%0b mode=%0d sat=%0b D=%0d -> Q=%0d rco=%0b load=%0b ovf=%0b wrap=%0d wrap2=%0d",
             txn, rst_i, en_i, mode_i, sat_i, d_i, q_a, rco_a, load_a, ovf_a, wrap_a, wrap_b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; mode = 2'b00; sat = 1'b0; D = '0;
    @(negedge clk);

    // reset state
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // count up 16 cycles: Q 1..15 then wrap to 0
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0);

    // load 13 then step by 3 wraps to 0
    step(1, 1, 3, 0, 13);
    step(1, 1, 2, 0, 0);

    // underflow clamp at 0 three times, then one modulo wrap to 15
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
    step(1, 1, 1, 0, 0);

    // step from 12 lands exactly on all-ones: rco=1, ovf stays clear
    step(1, 1, 3, 0, 12);
    step(1, 1, 2, 0, 0);

    // clamped step from 14, repeated at the boundary, then hold
    step(1, 1, 3, 0, 14);
    step(1, 1, 2, 1, 0);
    step(1, 1, 2, 1, 0);
    step(1, 0, 2, 1, 0);

    // five modulo wraps: the 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 3, 0, 15);
      step(1, 1, 0, 0, 0);
    end
    step(1, 1, 3, 0, 2);

    // reset in the same cycle as a load, then reset held while disabled
    step(0, 1, 3, 0, 9);
    step(0, 0, 0, 0, 0);
    step(0, 0, 2, 1, 5);

    // mixed traffic, including down-counting through zero and mode changes
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) != 0),
           int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
           int'($urandom_range(0, QMAX)));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_param.md
# counter_param

Parametrised, registered up/down/step/load counter with ripple-carry output, for the timing test benches and counter-chain datapaths. It generalises the fixed 4-bit mode counter used there:
- Width and jump step are parameters.
- `enable` gates counting.
- Per-operation saturate/wrap selection.
- A sticky overflow flag and a saturating wrap-event counter.

All outputs are registered; one clock domain.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits, ≥2.
- `STEP`, default 3: increment applied in mode 2'b10, 1 ≤ STEP < 2^WIDTH.
- `WRAP_W`, default 4: width of the wrap-event counter, ≥1.

Ports (reset is synchronous, active-low):
- `clk`: input, 1 bit. Rising-edge clock; the only clock.
- `reset`: input, 1 bit. Synchronous, active-low; sampled on `clk` rising edge.
- `enable`: input, 1 bit. Count/load qualifier.
- `mode`: input, 2 bits. 00 up by 1, 01 down by 1, 10 up by STEP, 11 load D.
- `sat`: input, 1 bit. 1 = clamp at boundary, 0 = modulo wrap.
- `D`: input, WIDTH bits. Load value.
- `Q`: output, WIDTH bits. Counter value.
- `rco`: output, 1 bit. Terminal-count flag for the current `Q`.
- `load`: output, 1 bit. High for the cycle following a load.
- `ovf`: output, 1 bit. Sticky over/underflow flag.
- `wrap_cnt`: output, WRAP_W bits. Number of modulo wraps, saturating.

## Operation
- Reset: if `reset`==0 at a clock edge, all of the following are forced, regardless of `enable` or `mode`:
  - `Q`=0, `rco`=0, `load`=0, `ovf`=0, `wrap_cnt`=0.
- Hold: `enable`==0 (with `reset`==1):
  - `Q`, `ovf`, `wrap_cnt` hold.
  - `rco`=0, `load`=0.
- Up (00) / Step (10):
  - Sum = Q + inc, inc = 1 or STEP, computed at WIDTH+1 bits.
  - No carry: `Q` = sum.
  - Carry with `sat`=0: `Q` = sum mod 2^WIDTH; `wrap_cnt`+1, saturating at 2^WRAP_W−1; `ovf`=1.
  - Carry with `sat`=1: `Q` = 2^WIDTH−1; `ovf`=1; `wrap_cnt` unchanged.
  - `rco` = (new Q == all-ones).
- Down (01):
  - Borrow occurs when Q==0.
  - `sat`=0: `Q` wraps to all-ones; `wrap_cnt`+1, saturating; `ovf`=1.
  - `sat`=1: `Q` stays 0; `ovf`=1.
  - `rco` = (new Q == 0).
- Load (11):
  - `Q`=D, `load`=1, `rco`=0.
  - `ovf` cleared to 0; `wrap_cnt` holds.
- `load`=0 in every non-load cycle.
- `sat` is sampled per cycle and affects only that cycle's update.

## Timing
- All state updates on the `clk` rising edge; latency 1 cycle from sampled inputs to outputs.
- No combinational input-to-output paths.
- `rco` is registered alongside `Q` and describes the `Q` it accompanies. The terminal value depends on the mode applied in that cycle: all-ones for 00/10, zero for 01.
- Step reaching exactly all-ones without carry: `rco`=1, `ovf` unchanged.
- Clamped saturation: `rco`=1 (Q equals terminal), `ovf`=1.
- Repeated saturating steps at the boundary keep `rco`=1 each cycle.
- `wrap_cnt` at max does not roll over; `ovf` still sets on wraps.
- Reset asserted mid-sequence, including in the same cycle as load or a wrap: reset wins, and every output is zero on the next cycle.
- Mode may change every cycle; no pipeline state carries between operations.

## Test plan
- Reset, then enable=1, mode=00, sat=0, 16 cycles (WIDTH=4) → Q 1..15,0. `rco`=1 only with Q=15. On the 16th cycle: `wrap_cnt`=1, `ovf`=1.
- Load D=4'hD, then mode=10, sat=0, STEP=3 → Q=D with `load`=1 for 1 cycle and `ovf`=0. Next cycle: Q=0 (wrap), `wrap_cnt`+1, `ovf`=1, `load`=0.
- Q=0, mode=01, sat=1, 3 cycles → Q stays 0, `rco`=1 each cycle, `ovf`=1, `wrap_cnt` unchanged. Then sat=0 for 1 cycle → Q=15, `rco`=0, `wrap_cnt`+1.
- Q=14, mode=10, sat=1 → Q=15, `rco`=1, `ovf`=1. Then enable=0 → Q holds 15, `rco`=0, `load`=0.
- WRAP_W=2: 5 modulo wraps → `wrap_cnt` sticks at 3. Then load D=2 → `ovf`=0, `wrap_cnt`=3.
- reset=0 in the same cycle as mode=11, D=9 → next cycle Q=0 and all flags 0. Reset held with enable=0 → outputs stay 0.
